multdiv_issue: RTL and testbench

Issue and writeback sequencer between the execute stage and the shared multiply/divide unit. Latches a multiply or divide request with its operands and destination register, pulses the unit's start, and stalls the pipeline while the unit iterates. It captures the result or exception into a writeback holding register, which it presents until the register file accepts it. It also enforces a watchdog timeout and supports pipeline flush.

---
 rtl/multdiv_issue.sv | 141 ++++++++++++++
 tb/tb_multdiv_issue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer for the shared multiply/divide unit.
// Optional feature: define MULTDIV_DIV0_BYPASS_EN to retire divide-by-zero without launching the unit.
module multdiv_issue #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  dest_reg,
  input  logic        flush,
  input  logic        wb_ack,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        md_start,
  output logic        md_should_div,
  output logic [31:0] md_op_a,
  output logic [31:0] md_op_b,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_exception
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_wdog;
  logic          r_md_start;
  logic          r_div;
  logic [31:0]   r_op_a;
  logic [31:0]   r_op_b;
  logic [4:0]    r_dest;
  logic          r_wb_valid;
  logic [31:0]   r_wb_data;
  logic [4:0]    r_wb_reg;
  logic          r_wb_exc;

  logic w_issue;
  logic w_div0;

  assign w_issue = issue_mult | issue_div;

`ifdef MULTDIV_DIV0_BYPASS_EN
  assign w_div0 = issue_div && (operand_b == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wdog     <= '0;
      r_md_start <= 1'b0;
      r_div      <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_dest     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_reg   <= '0;
      r_wb_exc   <= 1'b0;
    end else if (flush) begin
      // Flush outranks issue, md_ready, timeout and wb_ack alike.
      r_state    <= S_IDLE;
      r_md_start <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_op_a <= operand_a;
            r_op_b <= operand_b;
            r_dest <= dest_reg;
            r_div  <= issue_div;
            if (w_div0) begin
              r_state    <= S_WB;
              r_wb_valid <= 1'b1;
              r_wb_data  <= '0;
              r_wb_exc   <= 1'b1;
              r_wb_reg   <= dest_reg;
            end else begin
              r_state    <= S_LAUNCH;
              r_md_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          // md_ready here belongs to the previous operation and is ignored.
          r_md_start <= 1'b0;
          r_wdog     <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (md_ready) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= md_result;
            r_wb_exc   <= md_exception;
            r_wb_reg   <= r_dest;
            r_state    <= S_WB;
          end else if (r_wdog == CW'(TIMEOUT - 1)) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= '0;
            r_wb_exc   <= 1'b1;
            r_wb_reg   <= r_dest;
            r_state    <= S_WB;
          end else begin
            r_wdog <= r_wdog + CW'(1);
          end
        end
        S_WB: begin
          if (wb_ack) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_start      = r_md_start;
  assign md_should_div = r_div;
  assign md_op_a       = r_op_a;
  assign md_op_b       = r_op_b;
  assign stall         = (r_state != S_IDLE);
  assign wb_valid      = r_wb_valid;
  assign wb_data       = r_wb_data;
  assign wb_reg        = r_wb_reg;
  assign wb_exception  = r_wb_exc;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the unit is played by the stimulus tasks.
module tb_multdiv_issue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_mult = 1'b0;
  logic        issue_div = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  dest_reg = '0;
  logic        flush = 1'b0;
  logic        wb_ack = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_start;
  logic        md_should_div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_exception;

  int total = 0;
  int bad = 0;

  multdiv_issue #(.TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .issue_mult(issue_mult), .issue_div(issue_div),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .flush(flush), .wb_ack(wb_ack), .md_result(md_result),
    .md_exception(md_exception), .md_ready(md_ready), .md_start(md_start),
    .md_should_div(md_should_div), .md_op_a(md_op_a), .md_op_b(md_op_b),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++; if (md_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", md_start); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wbvalid got=%0b want=0", wb_valid); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wbdata got=%0d want=0", wb_data); end
    total++; if (md_op_a !== 32'd0) begin bad++; $display("FAIL reset_opa got=%0d want=0", md_op_a); end
  endtask

  task automatic test_mult();
    int starts;
    issue_mult = 1'b1; operand_a = 32'd7; operand_b = 32'd6; dest_reg = 5'd5;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mult_stall_comb got=%0b want=0", stall); end
    tick();
    issue_mult = 1'b0; operand_a = '0; operand_b = '0; dest_reg = '0;
    starts = (md_start === 1'b1) ? 1 : 0;
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL mult_launch_start got=%0b want=1", md_start); end
    total++; if (md_should_div !== 1'b0) begin bad++; $display("FAIL mult_sel got=%0b want=0", md_should_div); end
    total++; if (md_op_a !== 32'd7 || md_op_b !== 32'd6) begin bad++; $display("FAIL mult_ops got=%0d,%0d want=7,6", md_op_a, md_op_b); end
    for (int i = 0; i < 16; i++) begin
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_stall_%0d got=%0b want=1", i, stall); end
      tick();
      if (md_start === 1'b1) starts++;
    end
    md_ready = 1'b1; md_result = 32'd42; md_exception = 1'b0;
    tick();
    md_ready = 1'b0; md_result = '0;
    total++; if (starts != 1) begin bad++; $display("FAIL mult_start_count got=%0d want=1", starts); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL mult_wbvalid got=%0b want=1", wb_valid); end
    total++; if (wb_data !== 32'd42) begin bad++; $display("FAIL mult_wbdata got=%0d want=42", wb_data); end
    total++; if (wb_reg !== 5'd5) begin bad++; $display("FAIL mult_wbreg got=%0d want=5", wb_reg); end
    total++; if (wb_exception !== 1'b0) begin bad++; $display("FAIL mult_wbexc got=%0b want=0", wb_exception); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_wb_stall got=%0b want=1", stall); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    total++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL mult_idle got=stall%0b,valid%0b want=0,0", stall, wb_valid); end
  endtask

  task automatic test_div_hold();
    issue_div = 1'b1; operand_a = 32'd100; operand_b = 32'd7; dest_reg = 5'd9;
    tick();
    issue_div = 1'b0;
    total++; if (md_should_div !== 1'b1 || md_start !== 1'b1) begin bad++; $display("FAIL div_launch got=div%0b,start%0b want=1,1", md_should_div, md_start); end
    tick(); tick(); tick();
    md_ready = 1'b1; md_result = 32'd14;
    tick();
    md_ready = 1'b0; md_result = '0;
    for (int i = 0; i < 5; i++) begin
      issue_div = 1'b1; operand_a = 32'd1; operand_b = 32'd1; dest_reg = 5'd3;
      total++; if (wb_valid !== 1'b1 || wb_data !== 32'd14 || wb_reg !== 5'd9) begin
        bad++; $display("FAIL div_hold_%0d got=v%0b,d%0d,r%0d want=1,14,9", i, wb_valid, wb_data, wb_reg);
      end
      tick();
      total++; if (md_start !== 1'b0) begin bad++; $display("FAIL div_ignored_issue_%0d got=%0b want=0", i, md_start); end
    end
    issue_div = 1'b0;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    total++; if (stall !== 1'b0 || md_op_a !== 32'd100) begin bad++; $display("FAIL div_idle got=stall%0b,opa%0d want=0,100", stall, md_op_a); end
  endtask

  task automatic test_flush();
    flush = 1'b1; issue_mult = 1'b1; operand_a = 32'd9; operand_b = 32'd9; dest_reg = 5'd1;
    tick();
    flush = 1'b0; issue_mult = 1'b0;
    total++; if (stall !== 1'b0 || md_start !== 1'b0) begin bad++; $display("FAIL flush_idle_issue got=stall%0b,start%0b want=0,0", stall, md_start); end
    issue_mult = 1'b1; operand_a = 32'd3; operand_b = 32'd4; dest_reg = 5'd2;
    tick();
    issue_mult = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL flush_wait got=stall%0b,valid%0b want=0,0", stall, wb_valid); end
    md_ready = 1'b1; md_result = 32'd99;
    tick(); tick();
    md_ready = 1'b0; md_result = '0;
    total++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_late_ready got=valid%0b,stall%0b want=0,0", wb_valid, stall); end
    issue_mult = 1'b1; operand_a = 32'd2; operand_b = 32'd3; dest_reg = 5'd4;
    tick();
    issue_mult = 1'b0;
    total++; if (md_start !== 1'b1 || md_op_a !== 32'd2) begin bad++; $display("FAIL flush_relaunch got=start%0b,opa%0d want=1,2", md_start, md_op_a); end
    tick();
    md_ready = 1'b1; md_result = 32'd6;
    tick();
    md_ready = 1'b0; md_result = '0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'd6 || wb_reg !== 5'd4) begin bad++; $display("FAIL flush_relaunch_wb got=v%0b,d%0d,r%0d want=1,6,4", wb_valid, wb_data, wb_reg); end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    issue_mult = 1'b1; operand_a = 32'd1; operand_b = 32'd1; dest_reg = 5'd1;
    tick();
    issue_mult = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb_valid !== 1'b0 || stall !== 1'b1) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL timeout_early got=%0d want=0", early); end
    tick();
    total++; if (wb_valid !== 1'b1 || wb_exception !== 1'b1 || wb_data !== 32'd0 || wb_reg !== 5'd1) begin
      bad++; $display("FAIL timeout_wb got=v%0b,e%0b,d%0d,r%0d want=1,1,0,1", wb_valid, wb_exception, wb_data, wb_reg);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  task automatic test_div0();
    issue_div = 1'b1; operand_a = 32'd5; operand_b = 32'd0; dest_reg = 5'd7;
    tick();
    issue_div = 1'b0;
`ifdef MULTDIV_DIV0_BYPASS_EN
    total++; if (md_start !== 1'b0) begin bad++; $display("FAIL div0_start got=%0b want=0", md_start); end
    total++; if (wb_valid !== 1'b1 || wb_exception !== 1'b1 || wb_data !== 32'd0 || wb_reg !== 5'd7) begin
      bad++; $display("FAIL div0_wb got=v%0b,e%0b,d%0d,r%0d want=1,1,0,7", wb_valid, wb_exception, wb_data, wb_reg);
    end
`else
    total++; if (md_start !== 1'b1) begin bad++; $display("FAIL div0_start got=%0b want=1", md_start); end
    tick(); tick();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd0;
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_exception !== 1'b1 || wb_reg !== 5'd7) begin
      bad++; $display("FAIL div0_wb got=v%0b,e%0b,r%0d want=1,1,7", wb_valid, wb_exception, wb_reg);
    end
`endif
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL div0_idle got=%0b want=0", stall); end
  endtask

  task automatic test_both_reset();
    issue_mult = 1'b1; issue_div = 1'b1; operand_a = 32'd8; operand_b = 32'd2; dest_reg = 5'd6;
    tick();
    issue_mult = 1'b0; issue_div = 1'b0;
    total++; if (md_should_div !== 1'b1 || md_start !== 1'b1) begin bad++; $display("FAIL both_div_wins got=div%0b,start%0b want=1,1", md_should_div, md_start); end
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (stall !== 1'b0 || md_start !== 1'b0 || md_should_div !== 1'b0) begin
      bad++; $display("FAIL midreset_ctl got=stall%0b,start%0b,div%0b want=0,0,0", stall, md_start, md_should_div);
    end
    total++; if (md_op_a !== 32'd0 || md_op_b !== 32'd0) begin bad++; $display("FAIL midreset_ops got=%0d,%0d want=0,0", md_op_a, md_op_b); end
    total++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_reg !== 5'd0 || wb_exception !== 1'b0) begin
      bad++; $display("FAIL midreset_wb got=v%0b,d%0d,r%0d,e%0b want=0,0,0,0", wb_valid, wb_data, wb_reg, wb_exception);
    end
    md_ready = 1'b1; md_result = 32'd4;
    tick();
    md_ready = 1'b0;
    total++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL midreset_late_ready got=v%0b,stall%0b want=0,0", wb_valid, stall); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_hold();
    test_flush();
    test_timeout();
    test_div0();
    test_both_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
